lmc1992_mw_rx: RTL and testbench

// Microwire receiver and volume/mix stage modelling the STE LMC1992 chip.

---
 rtl/lmc1992_mw_rx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lmc1992_mw_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmc1992_mw_rx.sv
// lmc1992_mw_rx
// Microwire command receiver plus volume/tone/mix stage modelled on the
// STE LMC1992. Serial commands from the microwire master are synchronised,
// shifted in and decoded. The decoded settings scale the DMA and YM sample
// streams ahead of the audio DAC.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   mw_clk            microwire bit clock (asynchronous to clk)
//   mw_data           microwire serial data, MSB first
//   mw_enable         high while a microwire transfer is in progress
//   sample_stb        one-cycle pulse: new samples on dma_l/dma_r/ym_in
//   dma_l, dma_r      DMA samples, offset binary
//   ym_in             YM2149 sample, offset binary
//   out_l, out_r      signed mixed and attenuated samples
//   out_valid         one-cycle pulse, two cycles after sample_stb
//   bass, treble      current tone codes (0..12, 6 = flat)
//   cmd_stb           one-cycle pulse when a command is accepted; the new
//                     settings take effect for samples strobed after it
module lmc1992_mw_rx #(
  parameter int         MW_BITS     = 11,
  parameter logic [1:0] DEVICE_ADDR = 2'b10,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mw_clk,
  input  logic        mw_data,
  input  logic        mw_enable,
  input  logic        sample_stb,
  input  logic [7:0]  dma_l,
  input  logic [7:0]  dma_r,
  input  logic [7:0]  ym_in,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  output logic [3:0]  bass,
  output logic [3:0]  treble,
  output logic        cmd_stb
);

  localparam logic [4:0] MW_BITS_C = 5'(MW_BITS);

  // Limit a received code to the largest value the register accepts.
  function automatic logic [5:0] clamp_code(input logic [5:0] v, input logic [5:0] mx);
    if (v > mx) return mx;
    else        return v;
  endfunction

  // round(256 * 10^(-n/10)); attenuation of 2 dB per step, muted from n = 28 up.
  function automatic logic [8:0] coef_lut(input logic [6:0] n);
    case (n)
      7'd0:  return 9'd256;
      7'd1:  return 9'd203;
      7'd2:  return 9'd162;
      7'd3:  return 9'd128;
      7'd4:  return 9'd102;
      7'd5:  return 9'd81;
      7'd6:  return 9'd64;
      7'd7:  return 9'd51;
      7'd8:  return 9'd41;
      7'd9:  return 9'd32;
      7'd10: return 9'd26;
      7'd11: return 9'd20;
      7'd12: return 9'd16;
      7'd13: return 9'd13;
      7'd14: return 9'd10;
      7'd15: return 9'd8;
      7'd16: return 9'd6;
      7'd17: return 9'd5;
      7'd18: return 9'd4;
      7'd19: return 9'd3;
      7'd20: return 9'd3;
      7'd21: return 9'd2;
      7'd22: return 9'd2;
      7'd23: return 9'd1;
      7'd24: return 9'd1;
      7'd25: return 9'd1;
      7'd26: return 9'd1;
      7'd27: return 9'd1;
      default: return 9'd0;
    endcase
  endfunction

  // ---------------- microwire synchroniser ----------------
  logic [SYNC_STAGES-1:0] mwc_sync_q, mwd_sync_q, mwe_sync_q;
  logic                   mwc_prev_q, mwe_prev_q;
  logic                   mwc_s, mwd_s, mwe_s;
  logic                   mwc_rise_s, mwe_rise_s, mwe_fall_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      mwc_sync_q <= '0;
      mwd_sync_q <= '0;
      mwe_sync_q <= '0;
      mwc_prev_q <= 1'b0;
      mwe_prev_q <= 1'b0;
    end else begin
      mwc_sync_q[0] <= mw_clk;
      mwd_sync_q[0] <= mw_data;
      mwe_sync_q[0] <= mw_enable;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mwc_sync_q[i] <= mwc_sync_q[i-1];
        mwd_sync_q[i] <= mwd_sync_q[i-1];
        mwe_sync_q[i] <= mwe_sync_q[i-1];
      end
      mwc_prev_q <= mwc_s;
      mwe_prev_q <= mwe_s;
    end
  end

  always_comb begin
    mwc_s      = mwc_sync_q[SYNC_STAGES-1];
    mwd_s      = mwd_sync_q[SYNC_STAGES-1];
    mwe_s      = mwe_sync_q[SYNC_STAGES-1];
    mwc_rise_s = mwc_s & ~mwc_prev_q;
    mwe_rise_s = mwe_s & ~mwe_prev_q;
    mwe_fall_s = ~mwe_s & mwe_prev_q;
  end

  // ---------------- shift register and frame decode ----------------
  logic [10:0] sr_q, sr_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic        cmd_stb_q, cmd_stb_d;
  logic [2:0]  cmd_func_q, cmd_func_d;
  logic [5:0]  cmd_data_q, cmd_data_d;

  always_comb begin
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    cmd_stb_d  = 1'b0;
    cmd_func_d = cmd_func_q;
    cmd_data_d = cmd_data_q;
    if (mwe_s && mwc_rise_s) begin
      sr_d = {sr_q[9:0], mwd_s};
      if (bcnt_q != 5'd31) bcnt_d = bcnt_q + 5'd1;
    end
    // A new frame restarts the count; a bit clocked in the same cycle still counts.
    if (mwe_rise_s) bcnt_d = {4'd0, mwc_rise_s};
    // Functions 110/111 are not commands, so they never raise cmd_stb.
    if (mwe_fall_s && (bcnt_q >= MW_BITS_C) && (sr_q[10:9] == DEVICE_ADDR) &&
        (sr_q[8:7] != 2'b11)) begin
      cmd_stb_d  = 1'b1;
      cmd_func_d = sr_q[8:6];
      cmd_data_d = sr_q[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= 11'd0;
      bcnt_q     <= 5'd0;
      cmd_stb_q  <= 1'b0;
      cmd_func_q <= 3'd0;
      cmd_data_q <= 6'd0;
    end else begin
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      cmd_stb_q  <= cmd_stb_d;
      cmd_func_q <= cmd_func_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  // ---------------- settings registers ----------------
  // Written at the end of the cmd_stb cycle so a sample strobed alongside
  // cmd_stb still sees the previous settings.
  logic [5:0] master_q, master_d;
  logic [4:0] left_q, left_d, right_q, right_d;
  logic [3:0] bass_q, bass_d, treble_q, treble_d;
  logic [1:0] mix_q, mix_d;

  always_comb begin
    master_d = master_q;
    left_d   = left_q;
    right_d  = right_q;
    bass_d   = bass_q;
    treble_d = treble_q;
    mix_d    = mix_q;
    if (cmd_stb_q) begin
      case (cmd_func_q)
        3'b000:  mix_d    = cmd_data_q[1:0];
        3'b001:  bass_d   = 4'(clamp_code({2'd0, cmd_data_q[3:0]}, 6'd12));
        3'b010:  treble_d = 4'(clamp_code({2'd0, cmd_data_q[3:0]}, 6'd12));
        3'b011:  master_d = clamp_code(cmd_data_q, 6'd40);
        3'b100:  right_d  = 5'(clamp_code({1'b0, cmd_data_q[4:0]}, 6'd20));
        3'b101:  left_d   = 5'(clamp_code({1'b0, cmd_data_q[4:0]}, 6'd20));
        default: master_d = master_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      master_q <= 6'd40;
      left_q   <= 5'd20;
      right_q  <= 5'd20;
      bass_q   <= 4'd6;
      treble_q <= 4'd6;
      mix_q    <= 2'b01;
    end else begin
      master_q <= master_d;
      left_q   <= left_d;
      right_q  <= right_d;
      bass_q   <= bass_d;
      treble_q <= treble_d;
      mix_q    <= mix_d;
    end
  end

  // ---------------- mix and attenuation pipeline ----------------
  logic [6:0]        n_l_s, n_r_s, mix_att_s;
  logic signed [7:0] s_dma_l_s, s_dma_r_s, s_ym_s;
  logic signed [8:0] ym_term_s, sum_l_s, sum_r_s;

  always_comb begin
    mix_att_s = (mix_q == 2'b00) ? 7'd6 : 7'd0;
    n_l_s     = (7'd40 - {1'b0, master_q}) + (7'd20 - {2'd0, left_q})  + mix_att_s;
    n_r_s     = (7'd40 - {1'b0, master_q}) + (7'd20 - {2'd0, right_q}) + mix_att_s;
    // Offset binary to two's complement is an MSB flip.
    s_dma_l_s = signed'(dma_l ^ 8'h80);
    s_dma_r_s = signed'(dma_r ^ 8'h80);
    s_ym_s    = signed'(ym_in ^ 8'h80);
    ym_term_s = mix_q[1] ? 9'sd0 : 9'(s_ym_s);
    sum_l_s   = 9'(s_dma_l_s) + ym_term_s;
    sum_r_s   = 9'(s_dma_r_s) + ym_term_s;
  end

  logic signed [8:0]  sum_l_q, sum_r_q;
  logic [8:0]         coef_l_q, coef_r_q;
  logic               v1_q;
  logic signed [17:0] prod_l_s, prod_r_s;
  logic [15:0]        out_l_q, out_r_q;
  logic               out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_l_q  <= 9'sd0;
      sum_r_q  <= 9'sd0;
      coef_l_q <= 9'd0;
      coef_r_q <= 9'd0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= sample_stb;
      if (sample_stb) begin
        sum_l_q  <= sum_l_s;
        sum_r_q  <= sum_r_s;
        coef_l_q <= coef_lut(n_l_s);
        coef_r_q <= coef_lut(n_r_s);
      end
    end
  end

  always_comb begin
    prod_l_s = 18'(sum_l_q) * 18'($signed({1'b0, coef_l_q}));
    prod_r_s = 18'(sum_r_q) * 18'($signed({1'b0, coef_r_q}));
  end

  // Output is prod[16:1]; the product range never overflows 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_l_q     <= 16'd0;
      out_r_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_l_q <= 16'(prod_l_s >>> 1);
        out_r_q <= 16'(prod_r_s >>> 1);
      end
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign bass      = bass_q;
  assign treble    = treble_q;
  assign cmd_stb   = cmd_stb_q;

endmodule

// File: tb/tb_lmc1992_mw_rx.sv
// Scoreboard bench for lmc1992_mw_rx: stimulus pushes expected samples into a
// queue computed from a behavioural settings model; a negedge monitor pops and
// compares on every out_valid.
module tb_lmc1992_mw_rx;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mw_clk = 1'b0, mw_data = 1'b0, mw_enable = 1'b0, sample_stb = 1'b0;
  logic [7:0]  dma_l = 8'h80, dma_r = 8'h80, ym_in = 8'h80;
  logic [15:0] out_l, out_r;
  logic        out_valid, cmd_stb;
  logic [3:0]  bass, treble;

  lmc1992_mw_rx dut (
    .clk(clk), .reset(reset), .mw_clk(mw_clk), .mw_data(mw_data),
    .mw_enable(mw_enable), .sample_stb(sample_stb), .dma_l(dma_l),
    .dma_r(dma_r), .ym_in(ym_in), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .bass(bass), .treble(treble), .cmd_stb(cmd_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int cmd_cnt = 0, exp_cmds = 0;

  // behavioural settings model
  int m_master, m_left, m_right, m_bass, m_treble, m_mix;

  typedef struct { logic [15:0] l; logic [15:0] r; int cyc; } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_master = 40; m_left = 20; m_right = 20; m_bass = 6; m_treble = 6; m_mix = 1;
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int coef_of(int n);
    real r;
    if (n >= 40) return 0;
    r = 256.0 * $pow(10.0, -n / 10.0);
    return $rtoi(r + 0.5);
  endfunction

  function automatic logic [15:0] exp_out(int x, int y, int side);
    int n, c, s, p;
    n = (40 - m_master) + (20 - side) + ((m_mix == 0) ? 6 : 0);
    c = coef_of(n);
    s = (x - 128) + ((m_mix < 2) ? (y - 128) : 0);
    p = s * c;
    return 16'(p >>> 1);
  endfunction

  function automatic void model_apply(int func, int data);
    case (func)
      0: m_mix    = data & 3;
      1: m_bass   = min_i(data & 15, 12);
      2: m_treble = min_i(data & 15, 12);
      3: m_master = min_i(data, 40);
      4: m_right  = min_i(data & 31, 20);
      5: m_left   = min_i(data & 31, 20);
      default: ;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives sample_stb high for the coming edge and records the expectation.
  task automatic push_sample(logic [7:0] dl, logic [7:0] dr, logic [7:0] y);
    exp_t e;
    dma_l = dl; dma_r = dr; ym_in = y;
    sample_stb = 1'b1;
    e.l = exp_out(dl, y, m_left);
    e.r = exp_out(dr, y, m_right);
    e.cyc = cyc + 2;
    expq.push_back(e);
  endtask

  task automatic samples(int cnt, bit rnd, logic [7:0] dl, logic [7:0] dr, logic [7:0] y);
    for (int i = 0; i < cnt; i++) begin
      if (rnd) push_sample(8'($urandom), 8'($urandom), 8'($urandom));
      else     push_sample(dl, dr, y);
      tick(1);
    end
    sample_stb = 1'b0;
  endtask

  task automatic drain();
    tick(6);
    chk("queue_empty", expq.size(), 0);
  endtask

  task automatic send_frame(logic [1:0] addr, logic [2:0] func, logic [5:0] data,
                            int len, bit same_stb);
    logic [31:0] bits;
    logic [10:0] f;
    bit          exp_valid;
    int          ncmd;
    bit          stb_on;
    f = {addr, func, data};
    if (len >= 11) bits = ($urandom << 11) | {21'd0, f};
    else           bits = {21'd0, f} >> (11 - len);
    mw_enable = 1'b1;
    tick(4);
    for (int i = len - 1; i >= 0; i--) begin
      mw_data = bits[i];
      tick(3);
      mw_clk = 1'b1;
      tick(3);
      mw_clk = 1'b0;
    end
    tick(3);
    mw_enable = 1'b0;
    exp_valid = (len >= 11) && (addr == 2'b10) && (func < 3'd6);
    ncmd = 0;
    stb_on = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (stb_on) begin sample_stb = 1'b0; stb_on = 1'b0; end
      if (cmd_stb) begin
        ncmd++;
        // a sample strobed in the cmd_stb cycle must still use the old settings
        if (same_stb && ncmd == 1) begin
          push_sample(8'($urandom), 8'($urandom), 8'($urandom));
          stb_on = 1'b1;
        end
      end
    end
    sample_stb = 1'b0;
    chk("cmd_stb_count", ncmd, exp_valid ? 1 : 0);
    if (exp_valid) begin
      exp_cmds++;
      model_apply(func, data);
    end
    chk("bass", bass, m_bass);
    chk("treble", treble, m_treble);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && cmd_stb) cmd_cnt++;
    if (!reset && out_valid) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("out_l", out_l, mon_e.l);
        chk("out_r", out_r, mon_e.r);
        chk("out_valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_out_l", out_l, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cmd_stb", cmd_stb, 0);
    chk("rst_bass", bass, 6);
    chk("rst_treble", treble, 6);

    // 0 dB, single sample, then back-to-back
    samples(1, 0, 8'hC0, 8'hC0, 8'h80);
    drain();
    samples(3, 1, 8'h00, 8'h00, 8'h00);
    drain();

    // master=20, then restore and left=0
    send_frame(2'b10, 3'b011, 6'd20, 11, 0);
    samples(1, 0, 8'hC0, 8'hC0, 8'h80);
    drain();
    send_frame(2'b10, 3'b011, 6'd40, 11, 0);
    send_frame(2'b10, 3'b101, 6'd0, 11, 0);
    samples(1, 0, 8'hC0, 8'hC0, 8'h80);
    drain();

    // ignored frames: wrong address, short frame
    send_frame(2'b01, 3'b101, 6'd20, 11, 0);
    send_frame(2'b10, 3'b101, 6'd20, 9, 0);
    samples(1, 0, 8'hC0, 8'hC0, 8'h80);
    drain();

    // full-scale extremes at 0 dB
    send_frame(2'b10, 3'b101, 6'd20, 11, 0);
    samples(2, 0, 8'hFF, 8'hFF, 8'hFF);
    samples(1, 0, 8'h00, 8'h00, 8'h00);
    drain();

    // clamping, mute, tone codes, mix modes, longer frame
    send_frame(2'b10, 3'b011, 6'd41, 11, 0);
    send_frame(2'b10, 3'b101, 6'd31, 13, 0);
    send_frame(2'b10, 3'b001, 6'd15, 11, 0);
    send_frame(2'b10, 3'b010, 6'd3, 11, 0);
    send_frame(2'b10, 3'b110, 6'd5, 11, 0);
    samples(2, 1, 8'h00, 8'h00, 8'h00);
    send_frame(2'b10, 3'b011, 6'd0, 11, 0);
    send_frame(2'b10, 3'b101, 6'd0, 11, 0);
    samples(2, 1, 8'h00, 8'h00, 8'h00);
    send_frame(2'b10, 3'b011, 6'd40, 11, 0);
    send_frame(2'b10, 3'b000, 6'd0, 11, 0);
    samples(2, 1, 8'h00, 8'h00, 8'h00);
    send_frame(2'b10, 3'b000, 6'd2, 11, 0);
    samples(2, 1, 8'h00, 8'h00, 8'h00);
    drain();

    // sample strobed together with cmd_stb
    send_frame(2'b10, 3'b011, 6'd20, 11, 1);
    samples(1, 0, 8'hC0, 8'hC0, 8'h80);
    drain();

    // reset mid-transfer and mid-pipeline
    mw_enable = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      mw_data = 1'b1; tick(3); mw_clk = 1'b1; tick(3); mw_clk = 1'b0;
    end
    dma_l = 8'hC0; dma_r = 8'hC0; ym_in = 8'h80;
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
    reset = 1'b1;
    mw_enable = 1'b0;
    tick(2);
    reset = 1'b0;
    model_reset();
    tick(8);
    chk("post_rst_out_l", out_l, 0);
    chk("post_rst_out_r", out_r, 0);
    chk("post_rst_bass", bass, 6);
    chk("post_rst_treble", treble, 6);
    chk("post_rst_queue", expq.size(), 0);

    // randomized mix of frames and sample bursts
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 5) begin
        int       lsel, len;
        logic [1:0] a;
        a = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10;
        lsel = $urandom_range(0, 9);
        len = (lsel < 7) ? 11 : (lsel == 7) ? $urandom_range(9, 10) : $urandom_range(12, 14);
        send_frame(a, 3'($urandom_range(0, 7)), 6'($urandom), len,
                   $urandom_range(0, 3) == 0);
      end else begin
        samples($urandom_range(1, 4), 1, 8'h00, 8'h00, 8'h00);
        tick($urandom_range(0, 3));
      end
    end
    drain();
    chk("cmd_total", cmd_cnt, exp_cmds);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
